// File: rtl/l2_arb_pkg.sv
// Shared types and address-field positions for the L2 bus arbiter.
//   arb_state_t : arbiter FSM state (IDLE, GNT0, GNT1)
//   TAG_*/INDEX_* : bit positions of the block tag and index within a word address
package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int TAG_MSB   = 9;
  localparam int TAG_LSB   = 6;
  localparam int INDEX_MSB = 5;
  localparam int INDEX_LSB = 2;
  localparam int TAG_W     = TAG_MSB - TAG_LSB + 1;
  localparam int INDEX_W   = INDEX_MSB - INDEX_LSB + 1;

endpackage

// File: rtl/l2_bus_arbiter_snoop_pending_reg.sv
// One-entry pending-snoop holder for a single L1.
// Forwards the live snoop when there is one. If the L1 is busy while a live
// snoop is presented, the snoop is remembered (write beats read, newest
// tag/index kept) and replayed for exactly one cycle once the L1 goes idle
// with no live snoop competing.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   freeze             L2 busy: pending entry holds, no replay issued
//   l1_busy            target L1 is not idle
//   live_rd/live_wr    live snoop from the granted core
//   live_tag/index     tag/index of the live snoop
//   snp_rd/snp_wr      snoop request presented to the target L1
//   snp_tag/snp_index  tag/index presented to the target L1
//   replay             high in the cycle a pending snoop is replayed
module snoop_pending_reg
  import l2_arb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               freeze,
  input  logic               l1_busy,
  input  logic               live_rd,
  input  logic               live_wr,
  input  logic [TAG_W-1:0]   live_tag,
  input  logic [INDEX_W-1:0] live_index,
  output logic               snp_rd,
  output logic               snp_wr,
  output logic [TAG_W-1:0]   snp_tag,
  output logic [INDEX_W-1:0] snp_index,
  output logic               replay
);

  logic               pend_vld;
  logic               pend_wr;
  logic [TAG_W-1:0]   pend_tag;
  logic [INDEX_W-1:0] pend_index;
  logic               live;

  assign live   = live_rd | live_wr;
  assign replay = pend_vld & ~live & ~l1_busy & ~freeze;

  always_comb begin
    snp_rd    = 1'b0;
    snp_wr    = 1'b0;
    snp_tag   = '0;
    snp_index = '0;
    if (live) begin
      snp_rd    = live_rd;
      snp_wr    = live_wr;
      snp_tag   = live_tag;
      snp_index = live_index;
    end else if (replay) begin
      snp_rd    = ~pend_wr;
      snp_wr    = pend_wr;
      snp_tag   = pend_tag;
      snp_index = pend_index;
    end
  end

  // A live snoop delivered to an idle L1 makes any older pending one stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vld <= 1'b0;
      pend_wr  <= 1'b0;
    end else if (!freeze) begin
      if (live) begin
        if (l1_busy) begin
          pend_vld <= 1'b1;
          pend_wr  <= live_wr | (pend_vld & pend_wr);
        end else begin
          pend_vld <= 1'b0;
        end
      end else if (replay) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // Payload only matters while pend_vld is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!freeze && live && l1_busy) begin
      pend_tag   <= live_tag;
      pend_index <= live_index;
    end
  end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Shares the single L2 read/write port between two write-through L1 caches.
// Round-robin, transaction-granular grant; the winner's request is muxed to
// L2, the loser is stalled, and the winner's access is broadcast as a snoop
// to the other L1 (with a one-entry replay buffer if that L1 is busy).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   l2_busy_i                  L2 not ready: freezes arbiter, stalls both L1s
//   l1_rd_req_i/l1_wr_req_i    per-core read/write request
//   l1_addr_i/l1_wdata_i       per-core word address / write data (core0 in LSBs)
//   l1_busy_i                  per-core "L1 not idle"
//   l2_rd_req_o/l2_wr_req_o    request to L2
//   l2_addr_o/l2_wdata_o       address/data to L2 (hold last value when idle)
//   l1_stall_o                 per-core stall (L2_busy input of the L1)
//   snp_rd_o/snp_wr_o          per-core snoop read/write
//   snp_tag_o/snp_index_o      per-core snoop tag/index (core0 in LSBs)
//   stats_o                    {grants0, grants1, conflicts, snoop_replays}
module l2_bus_arbiter
  import l2_arb_pkg::*;
#(
  parameter int N      = 32,
  parameter int AW     = 10,
  parameter int STAT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                l2_busy_i,
  input  logic [1:0]          l1_rd_req_i,
  input  logic [1:0]          l1_wr_req_i,
  input  logic [2*AW-1:0]     l1_addr_i,
  input  logic [2*N-1:0]      l1_wdata_i,
  input  logic [1:0]          l1_busy_i,
  output logic                l2_rd_req_o,
  output logic                l2_wr_req_o,
  output logic [AW-1:0]       l2_addr_o,
  output logic [N-1:0]        l2_wdata_o,
  output logic [1:0]          l1_stall_o,
  output logic [1:0]          snp_rd_o,
  output logic [1:0]          snp_wr_o,
  output logic [2*TAG_W-1:0]  snp_tag_o,
  output logic [2*INDEX_W-1:0] snp_index_o,
  output logic [4*STAT_W-1:0] stats_o
);

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] cnt,
                                                input logic [1:0] inc);
    logic [STAT_W:0] sum;
    sum = {1'b0, cnt} + {{(STAT_W-1){1'b0}}, inc};
    return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
  endfunction

  arb_state_t        state, state_nxt;
  logic              last_winner, last_winner_nxt;
  logic              enter0, enter1, conflict;
  logic [1:0]        req;
  logic [1:0]        gnt_vec;
  logic              gnt_valid, gnt_core;
  logic              sel_rd, sel_wr;
  logic              eff_rd, eff_wr;
  logic [AW-1:0]     sel_addr, addr_hold;
  logic [N-1:0]      sel_wdata, wdata_hold;
  logic [STAT_W-1:0] grants0, grants1, conflicts, replays;
  logic [1:0]        live_rd, live_wr, replay;
  logic [TAG_W-1:0]  snp_tag_arr [2];
  logic [INDEX_W-1:0] snp_index_arr [2];

  assign req       = l1_rd_req_i | l1_wr_req_i;
  assign gnt_vec   = {state == GNT1, state == GNT0};
  assign gnt_valid = |gnt_vec;
  assign gnt_core  = gnt_vec[1];

  // Arbitration: ties in IDLE go to the core that did not win last.
  always_comb begin
    state_nxt       = state;
    last_winner_nxt = last_winner;
    enter0          = 1'b0;
    enter1          = 1'b0;
    conflict        = 1'b0;
    unique case (state)
      IDLE: begin
        if (req == 2'b11) begin
          conflict = 1'b1;
          if (last_winner) begin
            state_nxt = GNT0;
            enter0    = 1'b1;
          end else begin
            state_nxt = GNT1;
            enter1    = 1'b1;
          end
        end else if (req[0]) begin
          state_nxt = GNT0;
          enter0    = 1'b1;
        end else if (req[1]) begin
          state_nxt = GNT1;
          enter1    = 1'b1;
        end
      end
      GNT0: begin
        if (!req[0]) begin
          state_nxt       = IDLE;
          last_winner_nxt = 1'b0;
        end
      end
      GNT1: begin
        if (!req[1]) begin
          state_nxt       = IDLE;
          last_winner_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_winner <= 1'b1;
      grants0     <= '0;
      grants1     <= '0;
      conflicts   <= '0;
      replays     <= '0;
    end else if (!l2_busy_i) begin
      state       <= state_nxt;
      last_winner <= last_winner_nxt;
      grants0     <= sat_add(grants0, {1'b0, enter0});
      grants1     <= sat_add(grants1, {1'b0, enter1});
      conflicts   <= sat_add(conflicts, {1'b0, conflict});
      replays     <= sat_add(replays, {1'b0, replay[0]} + {1'b0, replay[1]});
    end
  end

  // L2 port mux; a simultaneous read and write from one core issues the read.
  assign sel_rd    = gnt_core ? l1_rd_req_i[1] : l1_rd_req_i[0];
  assign sel_wr    = gnt_core ? l1_wr_req_i[1] : l1_wr_req_i[0];
  assign sel_addr  = gnt_core ? l1_addr_i[2*AW-1:AW] : l1_addr_i[AW-1:0];
  assign sel_wdata = gnt_core ? l1_wdata_i[2*N-1:N] : l1_wdata_i[N-1:0];
  assign eff_rd    = gnt_valid & sel_rd;
  assign eff_wr    = gnt_valid & sel_wr & ~sel_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else if (gnt_valid) begin
      addr_hold  <= sel_addr;
      wdata_hold <= sel_wdata;
    end
  end

  assign l2_rd_req_o = eff_rd;
  assign l2_wr_req_o = eff_wr;
  assign l2_addr_o   = gnt_valid ? sel_addr : addr_hold;
  assign l2_wdata_o  = gnt_valid ? sel_wdata : wdata_hold;

  // Stall is forced low while reset is held so the L1s see a clean idle bus.
  assign l1_stall_o = reset ? 2'b00 : ({2{l2_busy_i}} | (req & ~gnt_vec));

  // Core j is snooped by the access of the other core.
  assign live_rd = {gnt_vec[0] & eff_rd, gnt_vec[1] & eff_rd};
  assign live_wr = {gnt_vec[0] & eff_wr, gnt_vec[1] & eff_wr};

  for (genvar j = 0; j < 2; j++) begin : g_snoop
    snoop_pending_reg u_pend (
      .clk        (clk),
      .reset      (reset),
      .freeze     (l2_busy_i),
      .l1_busy    (l1_busy_i[j]),
      .live_rd    (live_rd[j]),
      .live_wr    (live_wr[j]),
      .live_tag   (sel_addr[TAG_MSB:TAG_LSB]),
      .live_index (sel_addr[INDEX_MSB:INDEX_LSB]),
      .snp_rd     (snp_rd_o[j]),
      .snp_wr     (snp_wr_o[j]),
      .snp_tag    (snp_tag_arr[j]),
      .snp_index  (snp_index_arr[j]),
      .replay     (replay[j])
    );
  end

  assign snp_tag_o   = {snp_tag_arr[1], snp_tag_arr[0]};
  assign snp_index_o = {snp_index_arr[1], snp_index_arr[0]};
  assign stats_o     = {grants0, grants1, conflicts, replays};

endmodule

// File: tb/tb_l2_bus_arbiter.sv
module tb_l2_bus_arbiter;
  localparam int N = 32;
  localparam int AW = 10;
  localparam int STAT_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic l2b = 1'b0;
  logic [1:0] rd = 2'b00, wr = 2'b00, l1b = 2'b00;
  logic [AW-1:0] a0 = 10'h2C4, a1 = 10'h3A8;
  logic [N-1:0] d0 = 32'hDEAD_0000, d1 = 32'hBEEF_1111;

  logic l2_rd_req_o, l2_wr_req_o;
  logic [AW-1:0] l2_addr_o;
  logic [N-1:0] l2_wdata_o;
  logic [1:0] l1_stall_o, snp_rd_o, snp_wr_o;
  logic [7:0] snp_tag_o, snp_index_o;
  logic [4*STAT_W-1:0] stats_o;

  always #5 clk = ~clk;

  l2_bus_arbiter #(.N(N), .AW(AW), .STAT_W(STAT_W)) dut (
    .clk(clk), .reset(reset), .l2_busy_i(l2b),
    .l1_rd_req_i(rd), .l1_wr_req_i(wr),
    .l1_addr_i({a1, a0}), .l1_wdata_i({d1, d0}), .l1_busy_i(l1b),
    .l2_rd_req_o(l2_rd_req_o), .l2_wr_req_o(l2_wr_req_o),
    .l2_addr_o(l2_addr_o), .l2_wdata_o(l2_wdata_o),
    .l1_stall_o(l1_stall_o), .snp_rd_o(snp_rd_o), .snp_wr_o(snp_wr_o),
    .snp_tag_o(snp_tag_o), .snp_index_o(snp_index_o), .stats_o(stats_o)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: owner = -1 (bus free), 0 or 1; pending kind 0 none, 1 read, 2 write.
  int owner, last_win;
  int cnt[4];
  int pk[2];
  logic [3:0] ptag[2], pidx[2];
  logic [AW-1:0] m_addr;
  logic [N-1:0] m_wdata;

  logic e_rd, e_wr;
  logic [AW-1:0] e_addr;
  logic [N-1:0] e_wdata;
  logic [1:0] e_stall, e_srd, e_swr, rep_now;
  logic [7:0] e_stag, e_sidx;
  int live_k[2];

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    owner = -1; last_win = 1;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int k = 0; k < 2; k++) begin pk[k] = 0; ptag[k] = 0; pidx[k] = 0; end
    m_addr = '0; m_wdata = '0;
  endtask

  task automatic model_check();
    e_rd = 1'b0; e_wr = 1'b0; e_addr = m_addr; e_wdata = m_wdata;
    if (owner >= 0) begin
      e_rd = rd[owner];
      e_wr = wr[owner] && !rd[owner];
      e_addr = (owner == 0) ? a0 : a1;
      e_wdata = (owner == 0) ? d0 : d1;
    end
    for (int i = 0; i < 2; i++) e_stall[i] = l2b || ((rd[i] || wr[i]) && owner != i);
    e_srd = 0; e_swr = 0; e_stag = 0; e_sidx = 0; rep_now = 0;
    for (int j = 0; j < 2; j++) begin
      live_k[j] = 0;
      if (owner == 1 - j) live_k[j] = e_rd ? 1 : (e_wr ? 2 : 0);
      if (live_k[j] != 0) begin
        e_srd[j] = (live_k[j] == 1); e_swr[j] = (live_k[j] == 2);
        e_stag[4*j +: 4] = e_addr[9:6]; e_sidx[4*j +: 4] = e_addr[5:2];
      end else if (pk[j] != 0 && !l1b[j] && !l2b) begin
        rep_now[j] = 1'b1;
        e_srd[j] = (pk[j] == 1); e_swr[j] = (pk[j] == 2);
        e_stag[4*j +: 4] = ptag[j]; e_sidx[4*j +: 4] = pidx[j];
      end
    end
    chk("l2_port", 64'({l2_rd_req_o, l2_wr_req_o, l2_addr_o, l2_wdata_o}),
        64'({e_rd, e_wr, e_addr, e_wdata}));
    chk("stall", 64'(l1_stall_o), 64'(e_stall));
    chk("snoop", 64'({snp_rd_o, snp_wr_o, snp_tag_o, snp_index_o}),
        64'({e_srd, e_swr, e_stag, e_sidx}));
    chk("stats", 64'(stats_o), 64'({8'(cnt[0]), 8'(cnt[1]), 8'(cnt[2]), 8'(cnt[3])}));
  endtask

  task automatic model_advance();
    bit rq0, rq1, both;
    int w;
    rq0 = rd[0] || wr[0];
    rq1 = rd[1] || wr[1];
    if (!l2b) begin
      for (int j = 0; j < 2; j++) begin
        if (live_k[j] != 0) begin
          if (l1b[j]) begin
            pk[j] = (pk[j] > live_k[j]) ? pk[j] : live_k[j];
            ptag[j] = e_addr[9:6]; pidx[j] = e_addr[5:2];
          end else pk[j] = 0;
        end else if (rep_now[j]) begin
          pk[j] = 0; cnt[3] = sat(cnt[3] + 1);
        end
      end
      if (owner < 0) begin
        if (rq0 || rq1) begin
          both = rq0 && rq1;
          w = both ? ((last_win == 1) ? 0 : 1) : (rq0 ? 0 : 1);
          owner = w;
          cnt[w] = sat(cnt[w] + 1);
          if (both) cnt[2] = sat(cnt[2] + 1);
        end
      end else if (!(rd[owner] || wr[owner])) begin
        last_win = owner; owner = -1;
      end
    end
    m_addr = e_addr; m_wdata = e_wdata;
  endtask

  task automatic close_cycle();
    model_check();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    close_cycle();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("rst_l2", 64'({l2_rd_req_o, l2_wr_req_o, l2_addr_o, l2_wdata_o}), 64'd0);
    chk("rst_stall_snoop", 64'({l1_stall_o, snp_rd_o, snp_wr_o, snp_tag_o, snp_index_o}), 64'd0);
    chk("rst_stats", 64'(stats_o), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit         rst;
    logic [1:0] rd, wr;
    logic [7:0] exp;     // {stall[1:0], l2_rd, l2_wr, snp_rd[1:0], snp_wr[1:0]}
    bit         chk_st;
    logic [31:0] exp_st;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input logic [1:0] vr, input logic [1:0] vw,
                     input logic [7:0] e, input bit cs, input logic [31:0] es);
    vec_t v;
    v.rst = r; v.rd = vr; v.wr = vw; v.exp = e; v.chk_st = cs; v.exp_st = es;
    tbl.push_back(v);
  endtask

  initial begin
    model_reset();
    // core0 read transaction, one row with read+write (read wins)
    add(1, 2'b01, 2'b00, 8'b01_0_0_00_00, 0, 0);
    add(0, 2'b01, 2'b00, 8'b00_1_0_10_00, 0, 0);
    add(0, 2'b01, 2'b00, 8'b00_1_0_10_00, 0, 0);
    add(0, 2'b01, 2'b01, 8'b00_1_0_10_00, 0, 0);
    add(0, 2'b01, 2'b00, 8'b00_1_0_10_00, 0, 0);
    add(0, 2'b01, 2'b00, 8'b00_1_0_10_00, 0, 0);
    add(0, 2'b00, 2'b00, 8'b00_0_0_00_00, 0, 0);
    add(0, 2'b00, 2'b00, 8'b00_0_0_00_00, 1, 32'h0100_0000);
    // simultaneous requests after reset, then a second tie
    add(1, 2'b11, 2'b00, 8'b11_0_0_00_00, 0, 0);
    add(0, 2'b11, 2'b00, 8'b10_1_0_10_00, 0, 0);
    add(0, 2'b11, 2'b00, 8'b10_1_0_10_00, 0, 0);
    add(0, 2'b10, 2'b00, 8'b10_0_0_00_00, 0, 0);
    add(0, 2'b10, 2'b00, 8'b10_0_0_00_00, 0, 0);
    add(0, 2'b10, 2'b00, 8'b00_1_0_01_00, 0, 0);
    add(0, 2'b00, 2'b00, 8'b00_0_0_00_00, 0, 0);
    add(0, 2'b11, 2'b00, 8'b11_0_0_00_00, 0, 0);
    add(0, 2'b11, 2'b00, 8'b10_1_0_10_00, 0, 0);
    add(0, 2'b00, 2'b00, 8'b00_0_0_00_00, 1, 32'h0201_0200);
    // core0 write
    add(0, 2'b00, 2'b01, 8'b01_0_0_00_00, 0, 0);
    add(0, 2'b00, 2'b01, 8'b00_0_1_00_10, 0, 0);
    add(0, 2'b00, 2'b00, 8'b00_0_0_00_00, 0, 0);

    foreach (tbl[k]) begin
      if (tbl[k].rst) apply_reset();
      rd = tbl[k].rd; wr = tbl[k].wr; l1b = 2'b00; l2b = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d", k), 64'({l1_stall_o, l2_rd_req_o, l2_wr_req_o, snp_rd_o, snp_wr_o}),
          64'(tbl[k].exp));
      if (tbl[k].chk_st) chk($sformatf("vec%0d_stats", k), 64'(stats_o), 64'(tbl[k].exp_st));
      close_cycle();
    end

    // core1 write while L1 0 busy: pending snoop replayed when busy drops
    apply_reset();
    l1b = 2'b01; wr = 2'b10; rd = 2'b00;
    tick(); tick();
    wr = 2'b00;
    tick(); tick();
    l1b = 2'b00;
    @(negedge clk);
    chk("replay_pulse", 64'({snp_rd_o[0], snp_wr_o[0], snp_tag_o[3:0], snp_index_o[3:0]}),
        64'({1'b0, 1'b1, 4'hE, 4'hA}));
    close_cycle();
    @(negedge clk);
    chk("replay_once", 64'({snp_rd_o, snp_wr_o}), 64'd0);
    chk("replay_count", 64'(stats_o[7:0]), 64'd1);
    close_cycle();

    // L2 busy for 3 cycles in the middle of a core1 grant
    apply_reset();
    rd = 2'b10;
    tick(); tick();
    l2b = 1'b1;
    @(negedge clk);
    chk("l2busy_stall", 64'({l1_stall_o, l2_rd_req_o}), 64'({2'b11, 1'b1}));
    close_cycle();
    tick(); tick();
    l2b = 1'b0;
    @(negedge clk);
    chk("l2busy_resume", 64'({l1_stall_o, l2_rd_req_o, snp_rd_o}), 64'({2'b00, 1'b1, 2'b01}));
    close_cycle();
    rd = 2'b00;
    tick(); tick();

    // asynchronous reset in the middle of a core0 grant
    apply_reset();
    rd = 2'b01;
    tick(); tick();
    apply_reset();
    rd = 2'b00;
    tick();

    // alternating grants drive both grant counters into saturation
    apply_reset();
    for (int k = 0; k < 300; k++) begin
      rd = 2'b01; tick();
      rd = 2'b00; tick();
      rd = 2'b10; tick();
      rd = 2'b00; tick();
    end
    @(negedge clk);
    chk("grants_saturate", 64'(stats_o[31:16]), 64'(16'hFFFF));
    close_cycle();

    // randomized traffic against the model
    apply_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        rd[i] = ($urandom_range(0, 9) < 4);
        wr[i] = ($urandom_range(0, 9) < 3);
        l1b[i] = ($urandom_range(0, 2) == 0);
      end
      l2b = ($urandom_range(0, 7) == 0);
      a0 = 10'($urandom); a1 = 10'($urandom);
      d0 = $urandom; d1 = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
